// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI from WB through drain, TLB access, CP0 write-back and refetch flush
module tlb_op_ctrl #(
   parameter int TLBNUM = 16,
   localparam int IDXW = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            op_valid,
   input  logic [1:0]      op_type,
   input  logic [31:0]     op_pc,
   output logic            op_ready,
   input  logic            mem_idle,
   input  logic [31:0]     cp0_entryhi,
   input  logic [31:0]     cp0_index,
   input  logic            d_req,
   input  logic [18:0]     d_vpn2,
   input  logic            d_odd,
   output logic            d_gnt,
   output logic [18:0]     s1_vpn2,
   output logic            s1_odd,
   output logic [7:0]      s1_asid,
   input  logic            s1_found,
   input  logic [IDXW-1:0] s1_index,
   output logic            tlb_we,
   output logic [IDXW-1:0] tlb_w_index,
   output logic [IDXW-1:0] tlb_r_index,
   input  logic [18:0]     r_vpn2,
   input  logic [7:0]      r_asid,
   input  logic            r_g,
   input  logic [19:0]     r_pfn0,
   input  logic [2:0]      r_c0,
   input  logic            r_d0,
   input  logic            r_v0,
   input  logic [19:0]     r_pfn1,
   input  logic [2:0]      r_c1,
   input  logic            r_d1,
   input  logic            r_v1,
   output logic            tlbp_we,
   output logic [31:0]     tlbp_index,
   output logic            tlbr_we,
   output logic [31:0]     tlbr_entryhi,
   output logic [31:0]     tlbr_entrylo0,
   output logic [31:0]     tlbr_entrylo1,
   output logic            busy,
   output logic            flush_req,
   output logic [31:0]     flush_pc
);
   localparam logic [2:0] IDLE = 3'd0, DRAIN = 3'd1, EXEC = 3'd2, RESP = 3'd3, FLUSH = 3'd4;
   localparam logic [1:0] OP_P = 2'b01, OP_R = 2'b10, OP_WI = 2'b11;
   logic [2:0] state, state_n;
   logic [1:0] type_q;
   logic       accept, exec_p, exec_r;
   logic       unused_bits;
   assign unused_bits = ^{cp0_index[31:IDXW], cp0_entryhi[11:8]};
   assign op_ready = state == IDLE;
   assign busy = !op_ready;
   assign accept = op_valid && op_ready && op_type != 2'b00;
   assign exec_p = state == EXEC && type_q == OP_P;
   assign exec_r = state == EXEC && type_q == OP_R;
   // the data side loses the search port only during the TLBP probe cycle
   assign s1_vpn2 = exec_p ? cp0_entryhi[31:13] : d_vpn2;
   assign s1_odd = exec_p ? cp0_entryhi[12] : d_odd;
   assign s1_asid = cp0_entryhi[7:0];
   assign d_gnt = d_req && !exec_p;
   assign tlb_we = state == EXEC && type_q == OP_WI;
   assign tlb_w_index = cp0_index[IDXW-1:0];
   assign tlb_r_index = cp0_index[IDXW-1:0];
   assign tlbp_we = state == RESP && type_q == OP_P;
   assign tlbr_we = state == RESP && type_q == OP_R;
   assign flush_req = state == FLUSH;
   always_comb begin
      state_n = state == IDLE  ? (accept ? DRAIN : IDLE) :
                state == DRAIN ? (mem_idle ? EXEC : DRAIN) :
                state == EXEC  ? RESP :
                state == RESP  ? FLUSH : IDLE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         type_q <= '0;
         flush_pc <= '0;
         tlbp_index <= '0;
         tlbr_entryhi <= '0;
         tlbr_entrylo0 <= '0;
         tlbr_entrylo1 <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            type_q <= op_type;
            flush_pc <= op_pc + 32'd4;
         end
         if (exec_p) tlbp_index <= {~s1_found, {(31-IDXW){1'b0}}, s1_index};
         if (exec_r) begin
            tlbr_entryhi <= {r_vpn2, 5'b0, r_asid};
            tlbr_entrylo0 <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
            tlbr_entrylo1 <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
         end
      end
   end
endmodule
